// File: rtl/joy_io_multi.sv
// Multi-player joypad I/O: synchronised, debounced inputs with sticky START/SELECT
// capture (clear-on-status-read) and a latched per-player output port.
module joy_io_multi #(
  parameter int unsigned NPLAYERS = 2,
  parameter int unsigned IN_WIDTH = 10,
  parameter int unsigned DIV      = 12000,
  parameter int unsigned DB_COUNT = 8
) (
  input  logic                         CLK_12M,
  input  logic                         nRESET,
  input  logic [NPLAYERS*IN_WIDTH-1:0] P_IN,
  input  logic [NPLAYERS-1:0]          nCTRL_ZONE,
  input  logic                         M68K_ADDR4,
  output logic [15:0]                  M68K_DATA_OUT,
  output logic                         DATA_OE,
  input  logic                         nOUT_WR,
  input  logic [15:0]                  M68K_DATA_IN,
  output logic [3*NPLAYERS-1:0]        P_OUT
);

  localparam int unsigned NBITS = NPLAYERS * IN_WIDTH;
  localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0]    DB_MAX    = 8'(DB_COUNT - 1);

  logic [NBITS-1:0]    sync1_q, sync2_q;
  logic [NBITS-1:0]    stable_q, stable_d;
  logic [7:0]          cnt_q [NBITS];
  logic [7:0]          cnt_d [NBITS];
  logic [PW-1:0]       presc_q;
  logic                tick;
  logic [NPLAYERS-1:0] start_stk_q, start_stk_d;
  logic [NPLAYERS-1:0] sel_stk_q, sel_stk_d;
  logic [NPLAYERS-1:0] zone_q;
  logic [NPLAYERS-1:0] addr_last_q, addr_last_d;
  logic                wr_q;
  logic [3*NPLAYERS-1:0] p_out_q;

  logic unused_din;
  assign unused_din = ^M68K_DATA_IN[15:3*NPLAYERS];

  assign tick  = (presc_q == PRESC_MAX);
  assign P_OUT = p_out_q;

  // Per-bit debounce, only advanced on the prescaler tick
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      for (int i = 0; i < int'(NBITS); i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Sticky capture; a fresh press overrides a clear landing in the same cycle
  always_comb begin
    start_stk_d = start_stk_q;
    sel_stk_d   = sel_stk_q;
    addr_last_d = addr_last_q;
    for (int p = 0; p < int'(NPLAYERS); p++) begin
      logic clr;
      logic start_fall;
      logic sel_fall;
      clr        = ~zone_q[p] & nCTRL_ZONE[p] & addr_last_q[p];
      start_fall = stable_q[p*IN_WIDTH+8] & ~stable_d[p*IN_WIDTH+8];
      sel_fall   = stable_q[p*IN_WIDTH+9] & ~stable_d[p*IN_WIDTH+9];
      start_stk_d[p] = start_fall | (start_stk_q[p] & ~clr);
      sel_stk_d[p]   = sel_fall | (sel_stk_q[p] & ~clr);
      if (!nCTRL_ZONE[p]) addr_last_d[p] = M68K_ADDR4;
    end
  end

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      stable_q    <= '1;
      presc_q     <= '0;
      start_stk_q <= '0;
      sel_stk_q   <= '0;
      zone_q      <= '1;
      addr_last_q <= '0;
      wr_q        <= 1'b1;
      p_out_q     <= '0;
      for (int i = 0; i < int'(NBITS); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= P_IN;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      start_stk_q <= start_stk_d;
      sel_stk_q   <= sel_stk_d;
      zone_q      <= nCTRL_ZONE;
      addr_last_q <= addr_last_d;
      wr_q        <= nOUT_WR;
      if (wr_q && !nOUT_WR) p_out_q <= M68K_DATA_IN[3*NPLAYERS-1:0];
      for (int i = 0; i < int'(NBITS); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read mux: descending scan so the lowest-indexed active zone wins
  always_comb begin
    logic [IN_WIDTH-1:0] pl_stable;
    logic                pl_start;
    logic                pl_sel;
    pl_stable = '1;
    pl_start  = 1'b0;
    pl_sel    = 1'b0;
    for (int p = int'(NPLAYERS) - 1; p >= 0; p--) begin
      if (!nCTRL_ZONE[p]) begin
        pl_stable = stable_q[p*IN_WIDTH +: IN_WIDTH];
        pl_start  = start_stk_q[p];
        pl_sel    = sel_stk_q[p];
      end
    end
    DATA_OE = ~&nCTRL_ZONE;
    if (!DATA_OE) begin
      M68K_DATA_OUT = 16'hFFFF;
    end else if (M68K_ADDR4) begin
      M68K_DATA_OUT = {8'hFF, 4'hF, pl_sel, pl_start, pl_stable[9], pl_stable[8]};
    end else begin
      M68K_DATA_OUT = {8'hFF, pl_stable[7:0]};
    end
  end

endmodule

// File: tb/tb_joy_io_multi.sv
// Directed bench for joy_io_multi (2 players, DIV=4, DB_COUNT=3) with a queue scoreboard.
module tb_joy_io_multi;

  logic        CLK_12M = 1'b0;
  logic        nRESET;
  logic [19:0] p_in;
  logic [1:0]  zone;
  logic        addr4;
  logic [15:0] data;
  logic        oe;
  logic        nwr;
  logic [15:0] din;
  logic [5:0]  p_out;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  joy_io_multi #(
    .NPLAYERS(2),
    .IN_WIDTH(10),
    .DIV(4),
    .DB_COUNT(3)
  ) dut (
    .CLK_12M(CLK_12M),
    .nRESET(nRESET),
    .P_IN(p_in),
    .nCTRL_ZONE(zone),
    .M68K_ADDR4(addr4),
    .M68K_DATA_OUT(data),
    .DATA_OE(oe),
    .nOUT_WR(nwr),
    .M68K_DATA_IN(din),
    .P_OUT(p_out)
  );

  always #5 CLK_12M = ~CLK_12M;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK_12M);
    #1;
    cyc += n;
  endtask

  task automatic align(input int r);
    while (cyc % 4 != r) step(1);
  endtask

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  // Combinational read that never spans a clock edge, so no clear can happen
  task automatic peek(input int p, input logic a, input logic [15:0] e, input string t);
    zone    = 2'b11;
    zone[p] = 1'b0;
    addr4   = a;
    #1;
    push(t, {16'h0, e});
    check({16'h0, data});
    zone = 2'b11;
  endtask

  // Bus read held over one clock edge, then the strobe is released
  task automatic rd(input int p, input logic a, input logic [15:0] e, input string t);
    zone    = 2'b11;
    zone[p] = 1'b0;
    addr4   = a;
    #1;
    push(t, {16'h0, e});
    check({16'h0, data});
    step(1);
    zone = 2'b11;
    step(2);
  endtask

  initial begin
    int   first;
    logic ok;
    nRESET = 1'b0;
    p_in   = '1;
    zone   = 2'b11;
    addr4  = 1'b0;
    nwr    = 1'b1;
    din    = 16'h0000;
    step(3);
    nRESET = 1'b1;
    cyc    = 0;

    // Write something so the asynchronous reset has a value to clear
    din = 16'h0015;
    nwr = 1'b0;
    step(2);
    push("pre_write", 32'h15);
    check({26'h0, p_out});
    nwr = 1'b1;
    step(1);

    #4;
    nRESET = 1'b0;
    #1;
    push("rst_pout", 32'h0);
    check({26'h0, p_out});
    zone  = 2'b10;
    addr4 = 1'b0;
    #1;
    push("rst_btn", 32'hFFFF);
    check({16'h0, data});
    push("rst_oe", 32'h1);
    check({31'h0, oe});
    addr4 = 1'b1;
    #1;
    push("rst_status", 32'hFFF3);
    check({16'h0, data});
    zone  = 2'b11;
    addr4 = 1'b0;
    #1;
    push("rst_idle_data", 32'hFFFF);
    check({16'h0, data});
    push("rst_idle_oe", 32'h0);
    check({31'h0, oe});
    @(posedge CLK_12M);
    #1;
    nRESET = 1'b1;
    cyc    = 0;

    // Debounce acceptance window for P1 A
    zone  = 2'b10;
    addr4 = 1'b0;
    align(2);
    p_in[4] = 1'b0;
    first   = 0;
    for (int i = 1; i <= 18; i++) begin
      step(1);
      if (first == 0 && data[7:0] == 8'hEF) first = i;
    end
    ok = (first >= 14) && (first <= 18);
    push("acc_window", 32'h1);
    check({31'h0, ok});
    push("acc_word", 32'hFFEF);
    check({16'h0, data});
    p_in[4] = 1'b1;
    step(20);
    push("acc_release", 32'hFFFF);
    check({16'h0, data});

    // Two-tick glitch on P1 UP must never be accepted
    align(0);
    p_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      push("glitch_low", 32'hFFFF);
      check({16'h0, data});
    end
    p_in[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      push("glitch_after", 32'hFFFF);
      check({16'h0, data});
    end
    zone = 2'b11;

    // Sticky START on player 2
    p_in[18] = 1'b0;
    step(20);
    peek(1, 1'b1, 16'hFFF6, "p2_held");
    p_in[18] = 1'b1;
    step(20);
    peek(1, 1'b1, 16'hFFF7, "p2_released");
    rd(1, 1'b0, 16'hFFFF, "p2_btn_read");
    peek(1, 1'b1, 16'hFFF7, "p2_btn_no_clear");
    rd(1, 1'b1, 16'hFFF7, "p2_status_read");
    peek(1, 1'b1, 16'hFFF3, "p2_cleared");

    // START acceptance on player 1 lands on the same edge as the status-read clear
    align(2);
    p_in[8] = 1'b0;
    step(12);
    zone  = 2'b10;
    addr4 = 1'b1;
    #1;
    push("coll_pre", 32'hFFF3);
    check({16'h0, data});
    step(1);
    zone = 2'b11;
    step(1);
    peek(0, 1'b1, 16'hFFF6, "coll_set_wins");
    rd(0, 1'b1, 16'hFFF6, "coll_read");
    peek(0, 1'b1, 16'hFFF2, "coll_cleared");

    // Both zones low: player 1 wins
    zone  = 2'b00;
    addr4 = 1'b1;
    #1;
    push("multi_data", 32'hFFF2);
    check({16'h0, data});
    push("multi_oe", 32'h1);
    check({31'h0, oe});
    zone = 2'b11;
    #1;
    push("idle_oe", 32'h0);
    check({31'h0, oe});

    // Output port writes
    din = 16'h002D;
    nwr = 1'b0;
    step(2);
    push("wr_2d", 32'h2D);
    check({26'h0, p_out});
    din = 16'h0012;
    step(3);
    push("wr_held", 32'h2D);
    check({26'h0, p_out});
    nwr = 1'b1;
    step(1);
    nwr = 1'b0;
    step(2);
    push("wr_12", 32'h12);
    check({26'h0, p_out});
    nwr = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
